// File: rtl/execution_stage_mc_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, operand sources,
// control bundle, NZCV bit positions and multiply FSM states.
package GENERAL_DEFS;

  localparam int DEST_ADDR_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    ADD, SUB, AND, ORR, EOR, LSL, LSR, MOV, MUL
  } alu_control_signal;

  typedef enum logic [1:0] {
    SRC_REG, SRC_IMM, SRC_ACC
  } alu_input_source;

  typedef struct packed {
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   data_source;
    logic [DEST_ADDR_W-1:0] dest_addr;
  } exe_ctrl_t;

  typedef enum logic [1:0] {
    IDLE, MUL_BUSY, MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/execution_stage_mc_alu.sv
// Combinational ALU with NZCV generation; flags not produced by an op
// are passed through from flags_in.
module exe_alu
  import GENERAL_DEFS::*;
#(
  parameter int WORD_W = 32
) (
  input  alu_control_signal   op,
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  input  logic [3:0]          flags_in,
  output logic [WORD_W-1:0]   result,
  output logic [3:0]          flags_out
);

  logic [WORD_W:0] sum;
  logic [7:0]      shamt;

  always_comb begin
    sum       = '0;
    result    = '0;
    flags_out = flags_in;
    shamt     = b[7:0];
    unique case (op)
      ADD: begin
        sum               = {1'b0, a} + {1'b0, b};
        result            = sum[WORD_W-1:0];
        flags_out[FLAG_C] = sum[WORD_W];
        flags_out[FLAG_V] = (a[WORD_W-1] == b[WORD_W-1]) && (result[WORD_W-1] != a[WORD_W-1]);
      end
      SUB: begin
        // Two's-complement subtract: carry-out set means no borrow.
        sum               = {1'b0, a} + {1'b0, ~b} + {{WORD_W{1'b0}}, 1'b1};
        result            = sum[WORD_W-1:0];
        flags_out[FLAG_C] = sum[WORD_W];
        flags_out[FLAG_V] = (a[WORD_W-1] != b[WORD_W-1]) && (result[WORD_W-1] != a[WORD_W-1]);
      end
      AND: result = a & b;
      ORR: result = a | b;
      EOR: result = a ^ b;
      LSL: result = (int'(shamt) >= WORD_W) ? '0 : (a << shamt);
      LSR: result = (int'(shamt) >= WORD_W) ? '0 : (a >> shamt);
      MOV: result = b;
      MUL: result = a * b;
      default: result = '0;
    endcase
    flags_out[FLAG_N] = result[WORD_W-1];
    flags_out[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/execution_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU ops and a multi-cycle
// multiply FSM feeding one output pipeline register.
module execution_stage_mc
  import GENERAL_DEFS::*;
#(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_FWD    = 2,
  parameter int MUL_CYCLES = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      is_valid_i,
  output logic                      ready_o,
  input  alu_control_signal         alu_op_i,
  input  alu_input_source           src1_sel_i,
  input  alu_input_source           src2_sel_i,
  input  logic                      update_flag_i,
  input  logic [ADDR_W-1:0]         reg_1_addr_i,
  input  logic [ADDR_W-1:0]         reg_2_addr_i,
  input  logic [WORD_W-1:0]         reg_1_data_i,
  input  logic [WORD_W-1:0]         reg_2_data_i,
  input  logic [WORD_W-1:0]         immediate_i,
  input  logic [WORD_W-1:0]         accumulator_i,
  input  logic [NUM_FWD-1:0]        fwd_en_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
  input  logic [NUM_FWD*WORD_W-1:0] fwd_data_i,
  input  exe_ctrl_t                 ctrl_i,
  input  logic                      flush_i,
  input  logic                      downstream_ready_i,
  output logic                      is_valid_o,
  output exe_ctrl_t                 ctrl_o,
  output logic [WORD_W-1:0]         alu_result_o,
  output logic [WORD_W-1:0]         reg_2_data_o,
  output logic [3:0]                flags_o
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] fwd_1, fwd_2, op_1, op_2;
  logic [WORD_W-1:0] mul_a, mul_b, mul_r2;
  exe_ctrl_t         mul_ctrl;
  logic              mul_uf;

  alu_control_signal alu_op;
  logic [WORD_W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]        alu_flags;

  logic              accept, mul_finish, wr_now, wr_uf;
  exe_ctrl_t         wr_ctrl;
  logic [WORD_W-1:0] wr_r2;

  // Scan from the oldest source down so the youngest match wins.
  always_comb begin
    fwd_1 = reg_1_data_i;
    fwd_2 = reg_2_data_i;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (fwd_en_i[NUM_FWD-1-i] &&
          fwd_addr_i[(NUM_FWD-1-i)*ADDR_W +: ADDR_W] == reg_1_addr_i)
        fwd_1 = fwd_data_i[(NUM_FWD-1-i)*WORD_W +: WORD_W];
      if (fwd_en_i[NUM_FWD-1-i] &&
          fwd_addr_i[(NUM_FWD-1-i)*ADDR_W +: ADDR_W] == reg_2_addr_i)
        fwd_2 = fwd_data_i[(NUM_FWD-1-i)*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    unique case (src1_sel_i)
      SRC_IMM: op_1 = immediate_i;
      SRC_ACC: op_1 = accumulator_i;
      default: op_1 = fwd_1;
    endcase
    unique case (src2_sel_i)
      SRC_IMM: op_2 = immediate_i;
      SRC_ACC: op_2 = accumulator_i;
      default: op_2 = fwd_2;
    endcase
  end

  assign ready_o = (state == IDLE) && (!is_valid_o || downstream_ready_i) && !flush_i;
  assign accept  = is_valid_i && ready_o;

  // The shared ALU sees live operands when idle and the latched multiply otherwise.
  always_comb begin
    alu_op  = (state == IDLE) ? alu_op_i : MUL;
    alu_a   = (state == IDLE) ? op_1 : mul_a;
    alu_b   = (state == IDLE) ? op_2 : mul_b;
    wr_ctrl = (state == IDLE) ? ctrl_i : mul_ctrl;
    wr_r2   = (state == IDLE) ? fwd_2 : mul_r2;
    wr_uf   = (state == IDLE) ? update_flag_i : mul_uf;
  end

  // A finished multiply hands off only on a cycle the consumer is ready.
  assign mul_finish = ((state == MUL_BUSY) && (cnt == CNT_LAST)) || (state == MUL_DONE);
  assign wr_now     = (accept && (alu_op_i != MUL)) || (mul_finish && downstream_ready_i);

  exe_alu #(.WORD_W(WORD_W)) u_alu (
    .op        (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .flags_in  (flags_o),
    .result    (alu_res),
    .flags_out (alu_flags)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cnt          <= '0;
      is_valid_o   <= 1'b0;
      ctrl_o       <= '0;
      alu_result_o <= '0;
      reg_2_data_o <= '0;
      flags_o      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_r2       <= '0;
      mul_ctrl     <= '0;
      mul_uf       <= 1'b0;
    end else if (flush_i) begin
      state      <= IDLE;
      cnt        <= '0;
      is_valid_o <= 1'b0;
    end else begin
      if (wr_now) begin
        is_valid_o   <= 1'b1;
        ctrl_o       <= wr_ctrl;
        alu_result_o <= alu_res;
        reg_2_data_o <= wr_r2;
        if (wr_uf) flags_o <= alu_flags;
      end else if (downstream_ready_i) begin
        is_valid_o <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept && (alu_op_i == MUL)) begin
            state    <= MUL_BUSY;
            cnt      <= '0;
            mul_a    <= op_1;
            mul_b    <= op_2;
            mul_r2   <= fwd_2;
            mul_ctrl <= ctrl_i;
            mul_uf   <= update_flag_i;
          end
        end
        MUL_BUSY: begin
          if (cnt == CNT_LAST) state <= downstream_ready_i ? IDLE : MUL_DONE;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        MUL_DONE: begin
          if (downstream_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execution_stage_mc.sv
// Directed self-checking bench for execution_stage_mc.
module tb_execution_stage_mc;
  import GENERAL_DEFS::*;

  logic              clk_i, reset_i, is_valid_i, ready_o;
  alu_control_signal alu_op_i;
  alu_input_source   src1_sel_i, src2_sel_i;
  logic              update_flag_i;
  logic [3:0]        reg_1_addr_i, reg_2_addr_i;
  logic [31:0]       reg_1_data_i, reg_2_data_i, immediate_i, accumulator_i;
  logic [1:0]        fwd_en_i;
  logic [7:0]        fwd_addr_i;
  logic [63:0]       fwd_data_i;
  exe_ctrl_t         ctrl_i, ctrl_o;
  logic              flush_i, downstream_ready_i, is_valid_o;
  logic [31:0]       alu_result_o, reg_2_data_o;
  logic [3:0]        flags_o;

  int compared = 0;
  int mismatched = 0;

  execution_stage_mc #(.WORD_W(32), .ADDR_W(4), .NUM_FWD(2), .MUL_CYCLES(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .is_valid_i(is_valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .src1_sel_i(src1_sel_i), .src2_sel_i(src2_sel_i),
    .update_flag_i(update_flag_i), .reg_1_addr_i(reg_1_addr_i), .reg_2_addr_i(reg_2_addr_i),
    .reg_1_data_i(reg_1_data_i), .reg_2_data_i(reg_2_data_i), .immediate_i(immediate_i),
    .accumulator_i(accumulator_i), .fwd_en_i(fwd_en_i), .fwd_addr_i(fwd_addr_i),
    .fwd_data_i(fwd_data_i), .ctrl_i(ctrl_i), .flush_i(flush_i),
    .downstream_ready_i(downstream_ready_i), .is_valid_o(is_valid_o), .ctrl_o(ctrl_o),
    .alu_result_o(alu_result_o), .reg_2_data_o(reg_2_data_o), .flags_o(flags_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input alu_control_signal op, input alu_input_source s1, input alu_input_source s2,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [31:0] acc, input logic uf, input logic [7:0] ctl);
    is_valid_i    = 1'b1;
    alu_op_i      = op;
    src1_sel_i    = s1;
    src2_sel_i    = s2;
    reg_1_data_i  = r1;
    reg_2_data_i  = r2;
    immediate_i   = imm;
    accumulator_i = acc;
    update_flag_i = uf;
    ctrl_i        = ctl;
  endtask

  initial begin
    reset_i = 1'b1; is_valid_i = 1'b0; alu_op_i = ADD; src1_sel_i = SRC_REG; src2_sel_i = SRC_REG;
    update_flag_i = 1'b0; reg_1_addr_i = 4'd1; reg_2_addr_i = 4'd2; reg_1_data_i = '0; reg_2_data_i = '0;
    immediate_i = '0; accumulator_i = '0; fwd_en_i = '0; fwd_addr_i = '0; fwd_data_i = '0;
    ctrl_i = '0; flush_i = 1'b0; downstream_ready_i = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(is_valid_o), 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_result", alu_result_o, 32'd0);

    // ADD overflow in the first cycle after reset release
    reset_i = 1'b0;
    issue(ADD, SRC_REG, SRC_REG, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 8'h25);
    #1 check("first_ready", 32'(ready_o), 32'd1);
    tick();
    check("add_valid", 32'(is_valid_o), 32'd1);
    check("add_result", alu_result_o, 32'h8000_0000);
    check("add_flags", 32'(flags_o), 32'b1001);
    check("add_ctrl", 32'(ctrl_o), 32'h25);
    check("add_r2", reg_2_data_o, 32'h1);

    // SUB 5-3 from immediate; reg_2_data_o carries the register value
    issue(SUB, SRC_REG, SRC_IMM, 32'd5, 32'h1234, 32'd3, 32'h0, 1'b1, 8'h00);
    tick();
    check("sub_result", alu_result_o, 32'd2);
    check("sub_flags", 32'(flags_o), 32'b0010);
    check("sub_r2", reg_2_data_o, 32'h1234);

    // forwarding: both sources hit address 3, youngest (index 0) wins
    issue(ORR, SRC_REG, SRC_IMM, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 8'h00);
    reg_1_addr_i = 4'd3; reg_2_addr_i = 4'd3;
    fwd_en_i = 2'b11; fwd_addr_i = {4'd3, 4'd3}; fwd_data_i = {32'hBB, 32'hAA};
    tick();
    check("fwd_both", alu_result_o, 32'hAA);
    check("fwd_r2", reg_2_data_o, 32'hAA);
    check("noflag_hold", 32'(flags_o), 32'b0010);
    fwd_en_i = 2'b10;
    tick();
    check("fwd_idx1", alu_result_o, 32'hBB);
    fwd_en_i = 2'b00; reg_1_addr_i = 4'd1; reg_2_addr_i = 4'd2;

    // shifts: amount >= width gives 0 with C held
    issue(LSL, SRC_REG, SRC_IMM, 32'd1, 32'h0, 32'd32, 32'h0, 1'b1, 8'h00);
    tick();
    check("lsl32_result", alu_result_o, 32'd0);
    check("lsl32_flags", 32'(flags_o), 32'b0110);
    issue(LSL, SRC_REG, SRC_IMM, 32'd1, 32'h0, 32'd31, 32'h0, 1'b0, 8'h00);
    tick();
    check("lsl31", alu_result_o, 32'h8000_0000);
    issue(LSR, SRC_REG, SRC_IMM, 32'h8000_0000, 32'h0, 32'd4, 32'h0, 1'b0, 8'h00);
    tick();
    check("lsr4", alu_result_o, 32'h0800_0000);

    // stall: output holds while downstream is not ready
    downstream_ready_i = 1'b0;
    issue(ADD, SRC_IMM, SRC_IMM, 32'h0, 32'h0, 32'd9, 32'h0, 1'b1, 8'h00);
    #1 check("stall_ready", 32'(ready_o), 32'd0);
    tick();
    check("stall_valid", 32'(is_valid_o), 32'd1);
    check("stall_result", alu_result_o, 32'h0800_0000);
    check("stall_flags", 32'(flags_o), 32'b0110);
    is_valid_i = 1'b0; downstream_ready_i = 1'b1;
    tick();
    check("drain_valid", 32'(is_valid_o), 32'd0);

    // MUL 6*7: four busy cycles, operands latched at acceptance
    issue(MUL, SRC_ACC, SRC_IMM, 32'h0, 32'h55, 32'd7, 32'd6, 1'b1, 8'h3A);
    tick();
    is_valid_i = 1'b0; accumulator_i = 32'd100; reg_2_data_i = 32'h99;
    for (int i = 0; i < 4; i++) begin
      check("mul_busy_ready", 32'(ready_o), 32'd0);
      check("mul_busy_valid", 32'(is_valid_o), 32'd0);
      tick();
    end
    check("mul_valid", 32'(is_valid_o), 32'd1);
    check("mul_result", alu_result_o, 32'd42);
    check("mul_flags", 32'(flags_o), 32'b0010);
    check("mul_ctrl", 32'(ctrl_o), 32'h3A);
    check("mul_r2", reg_2_data_o, 32'h55);
    check("mul_ready_after", 32'(ready_o), 32'd1);

    // MUL finishing while downstream is stalled parks in MUL_DONE
    issue(MUL, SRC_ACC, SRC_IMM, 32'h0, 32'h0, 32'd2, 32'hFFFF_FFFF, 1'b1, 8'h3A);
    tick();
    is_valid_i = 1'b0; downstream_ready_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("done_valid", 32'(is_valid_o), 32'd0);
    check("done_ready", 32'(ready_o), 32'd0);
    tick();
    check("done_wait_valid", 32'(is_valid_o), 32'd0);
    downstream_ready_i = 1'b1;
    #1 check("done_ready_hi_dr", 32'(ready_o), 32'd0);
    tick();
    check("done_out_valid", 32'(is_valid_o), 32'd1);
    check("done_result", alu_result_o, 32'hFFFF_FFFE);
    check("done_flags", 32'(flags_o), 32'b1010);

    // flush in the second busy cycle kills the multiply
    issue(MUL, SRC_IMM, SRC_ACC, 32'h0, 32'h0, 32'd0, 32'd5, 1'b1, 8'h11);
    tick();
    is_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    #1 check("flush_ready", 32'(ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    check("flush_valid", 32'(is_valid_o), 32'd0);
    #1 check("flush_idle_ready", 32'(ready_o), 32'd1);
    tick(); tick(); tick(); tick();
    check("flush_stays_invalid", 32'(is_valid_o), 32'd0);
    check("flush_flags", 32'(flags_o), 32'b1010);
    check("flush_result_held", alu_result_o, 32'hFFFF_FFFE);

    // reset mid-multiply clears everything at once
    issue(MUL, SRC_ACC, SRC_IMM, 32'h0, 32'h0, 32'd7, 32'd6, 1'b1, 8'h3A);
    tick();
    is_valid_i = 1'b0;
    tick();
    reset_i = 1'b1;
    #1;
    check("mrst_valid", 32'(is_valid_o), 32'd0);
    check("mrst_result", alu_result_o, 32'd0);
    check("mrst_flags", 32'(flags_o), 32'd0);
    check("mrst_ctrl", 32'(ctrl_o), 32'd0);
    check("mrst_r2", reg_2_data_o, 32'd0);
    tick();
    reset_i = 1'b0;
    #1 check("mrst_ready", 32'(ready_o), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    check("mrst_no_result", 32'(is_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execution_stage_mc.md
EXECUTION_STAGE_MC -- requirements
Module: execution_stage_mc

Interface
REQ-001 Parameter WORD_W, default 32, datapath width in bits.
REQ-002 Parameter ADDR_W, default 4, register address width.
REQ-003 Parameter NUM_FWD, default 2, number of forwarding sources; index 0 is the youngest.
REQ-004 Parameter MUL_CYCLES, default 4, multiply latency in cycles; legal range 2..16.
REQ-005 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 is_valid_i  in  1  issue slot holds a real instruction.
REQ-008 ready_o  out  1  stage accepts an instruction this cycle.
REQ-009 alu_op_i  in  alu_control_signal  one of ADD, SUB, AND, ORR, EOR, LSL, LSR, MOV, MUL.
REQ-010 src1_sel_i / src2_sel_i  in  alu_input_source  each selects register, immediate or accumulator.
REQ-011 update_flag_i  in  1  commit NZCV for this instruction.
REQ-012 reg_1_addr_i / reg_2_addr_i  in  ADDR_W  source register addresses.
REQ-013 reg_1_data_i / reg_2_data_i  in  WORD_W  register-file read data.
REQ-014 immediate_i / accumulator_i  in  WORD_W  immediate and accumulator operands.
REQ-015 fwd_en_i  in  NUM_FWD  forwarding source n writes the register file.
REQ-016 fwd_addr_i  in  NUM_FWD*ADDR_W  destination address of source n, packed.
REQ-017 fwd_data_i  in  NUM_FWD*WORD_W  result data of source n, packed.
REQ-018 ctrl_i  in  exe_ctrl_t  {mem_read, mem_write, reg_write, data_source, dest_addr}.
REQ-019 flush_i  in  1  kill the in-flight and output instruction.
REQ-020 downstream_ready_i  in  1  next stage consumes the output this cycle.
REQ-021 is_valid_o  out  1  output register holds a valid result.
REQ-022 ctrl_o  out  exe_ctrl_t  registered copy of ctrl_i.
REQ-023 alu_result_o / reg_2_data_o  out  WORD_W  registered result and forwarded store data.
REQ-024 flags_o  out  4  architectural NZCV.

Function
REQ-025 An instruction is accepted when is_valid_i && ready_o; ready_o = (state==IDLE) && (!is_valid_o || downstream_ready_i) && !flush_i.
REQ-026 Operand forwarding: the lowest-index source n with fwd_en_i[n] and a matching address replaces the register data; otherwise register-file data is used.
REQ-027 Non-MUL ops are written to the output register on the edge after acceptance (latency 1).
REQ-028 ADD/SUB compute a WORD_W+1-bit sum; C is the carry-out (SUB: C = no borrow); V is signed overflow.
REQ-029 LSL/LSR shift by operand2[7:0]; an amount >= WORD_W yields 0; C is unchanged.
REQ-030 MUL yields the low WORD_W bits of the product; only N and Z update, C and V hold.
REQ-031 The FSM has three states: IDLE, MUL_BUSY and MUL_DONE.
REQ-032 IDLE -> MUL_BUSY on accepting a MUL; the forwarded operands and ctrl_i are latched at acceptance.
REQ-033 MUL_BUSY counts MUL_CYCLES-1 cycles, then the result is written if the output slot is free (-> IDLE); otherwise the FSM moves to MUL_DONE.
REQ-034 MUL_DONE holds the result until the slot frees, then writes it and returns to IDLE.
REQ-035 When is_valid_o && !downstream_ready_i, all outputs hold unchanged.
REQ-036 flags_o updates only at the edge that writes a valid result with update_flag_i set.
REQ-037 flush_i clears is_valid_o and returns the FSM to IDLE on the next edge, with priority over all other events; flags are not updated by a killed instruction.
REQ-038 reg_2_data_o carries the forwarded operand-2 register value, not the immediate.

Reset
REQ-039 reset_i clears is_valid_o, ctrl_o, alu_result_o, reg_2_data_o, flags_o and the counter to 0 and sets the FSM to IDLE, including mid-multiply.
REQ-040 The first acceptance after reset is possible in the first cycle in which reset_i is low.

Structure
REQ-041 alu_control_signal, alu_input_source, exe_ctrl_t and the NZCV bit indices are defined in the shared GENERAL_DEFS package.
REQ-042 The ALU/flag logic is a combinational sub-module exe_alu; the multiply FSM and the pipeline register live in execution_stage_mc.

Verification
REQ-043 ADD 0x7FFFFFFF+1 with update_flag_i set -> the next cycle has result 0x80000000 and NZCV=1001.
REQ-044 reg_1_addr=3 with fwd_en=11, both fwd_addr=3, data {0xAA, 0xBB} (index 0 = 0xAA) -> operand 1 = 0xAA.
REQ-045 MUL 6*7 with MUL_CYCLES=4 -> ready_o low for 4 cycles, then result 42 with is_valid_o high and C,V unchanged.
REQ-046 MUL completes with downstream_ready_i low -> FSM enters MUL_DONE; 42 appears one cycle after ready rises.
REQ-047 flush_i in the second MUL_BUSY cycle -> is_valid_o stays 0, FSM returns to IDLE, flags unchanged.
REQ-048 reset_i asserted mid-multiply -> all outputs 0 immediately and ready_o high after release.
